axi_mem_responder: RTL



---
 rtl/axi_mem_responder_if.sv | 69 ++++++
 rtl/axi_mem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_responder_if.sv
// axi_mem_responder_if: AXI4 AR/R/AW/W/B channel bundle for axi_mem_responder.
// Signal suffixes (_i/_o) are named from the responder's point of view.
interface axi_mem_responder_if #(
   parameter int AddrWidth = 64,
   parameter int DataWidth = 64,
   parameter int IdWidth   = 4
);
   logic                   ar_valid_i;
   logic                   ar_ready_o;
   logic [IdWidth-1:0]     ar_id_i;
   logic [AddrWidth-1:0]   ar_addr_i;
   logic [7:0]             ar_len_i;
   logic [2:0]             ar_size_i;
   logic [1:0]             ar_burst_i;

   logic                   r_valid_o;
   logic                   r_ready_i;
   logic [IdWidth-1:0]     r_id_o;
   logic [DataWidth-1:0]   r_data_o;
   logic [1:0]             r_resp_o;
   logic                   r_last_o;

   logic                   aw_valid_i;
   logic                   aw_ready_o;
   logic [IdWidth-1:0]     aw_id_i;
   logic [AddrWidth-1:0]   aw_addr_i;
   logic [7:0]             aw_len_i;
   logic [2:0]             aw_size_i;
   logic [1:0]             aw_burst_i;

   logic                   w_valid_i;
   logic                   w_ready_o;
   logic [DataWidth-1:0]   w_data_i;
   logic [DataWidth/8-1:0] w_strb_i;
   logic                   w_last_i;

   logic                   b_valid_o;
   logic                   b_ready_i;
   logic [IdWidth-1:0]     b_id_o;
   logic [1:0]             b_resp_o;

   // Responder side
   modport slave (
      input  ar_valid_i, ar_id_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i,
      output ar_ready_o,
      output r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o,
      input  r_ready_i,
      input  aw_valid_i, aw_id_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i,
      output aw_ready_o,
      input  w_valid_i, w_data_i, w_strb_i, w_last_i,
      output w_ready_o,
      output b_valid_o, b_id_o, b_resp_o,
      input  b_ready_i
   );

   // Requester side
   modport master (
      output ar_valid_i, ar_id_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i,
      input  ar_ready_o,
      input  r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o,
      output r_ready_i,
      output aw_valid_i, aw_id_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i,
      input  aw_ready_o,
      output w_valid_i, w_data_i, w_strb_i, w_last_i,
      input  w_ready_o,
      input  b_valid_o, b_id_o, b_resp_o,
      output b_ready_i
   );
endinterface

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 subordinate memory model with independent read and
// write FSMs (one burst of each in flight), returning the request ID on R/B.
// Optional feature macro AXI_MEM_RESP_ERR_EN: addresses beyond the array are
// answered with SLVERR (reads return 0, writes are dropped) instead of wrapping.
module axi_mem_responder #(
   parameter int AddrWidth = 64,
   parameter int DataWidth = 64,
   parameter int IdWidth   = 4,
   parameter int MemWords  = 1024
) (
   input  logic               clk_i,
   input  logic               rst_i,
   axi_mem_responder_if.slave bus
);
   localparam int StrbWidth = DataWidth / 8;
   localparam int OffW      = $clog2(StrbWidth);
   localparam int IdxW      = $clog2(MemWords);
   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlverr = 2'b10;

   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

   // INCR and WRAP step by the beat size; FIXED and the reserved type hold.
   function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] a,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
      if (burst == 2'b01 || burst == 2'b10) return a + (AddrWidth'(1) << size);
      return a;
   endfunction

   logic [DataWidth-1:0] mem_q [MemWords];

   r_state_e             r_state_q, r_state_d;
   logic [IdWidth-1:0]   r_id_q, r_id_d;
   logic [AddrWidth-1:0] rd_addr_q, rd_addr_d;
   logic [7:0]           rd_len_q, rd_len_d;
   logic [7:0]           rd_cnt_q, rd_cnt_d;
   logic [2:0]           rd_size_q, rd_size_d;
   logic [1:0]           rd_burst_q, rd_burst_d;
   logic [DataWidth-1:0] r_data_q, r_data_d;
   logic [1:0]           r_resp_q, r_resp_d;

   w_state_e             w_state_q, w_state_d;
   logic [IdWidth-1:0]   b_id_q, b_id_d;
   logic [AddrWidth-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]           wr_len_q, wr_len_d;
   logic [7:0]           wr_cnt_q, wr_cnt_d;
   logic [2:0]           wr_size_q, wr_size_d;
   logic [1:0]           wr_burst_q, wr_burst_d;
   logic                 b_err_q, b_err_d;

   logic                 mem_we;
   logic                 rd_oor, wr_oor;
   logic                 unused_w_last;

   // w_last_i is not trusted; the burst length comes from aw_len_i.
   assign unused_w_last = bus.w_last_i;

`ifdef AXI_MEM_RESP_ERR_EN
   assign rd_oor = |(rd_addr_q >> (OffW + IdxW));
   assign wr_oor = |(wr_addr_q >> (OffW + IdxW));
`else
   assign rd_oor = 1'b0;
   assign wr_oor = 1'b0;
`endif

   // Read FSM: accept AR, fetch one word per beat, present it until accepted.
   always_comb begin
      // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
      r_state_d  = r_state_q;
      r_id_d     = r_id_q;
      rd_addr_d  = rd_addr_q;
      rd_len_d   = rd_len_q;
      rd_cnt_d   = rd_cnt_q;
      rd_size_d  = rd_size_q;
      rd_burst_d = rd_burst_q;
      r_data_d   = r_data_q;
      r_resp_d   = r_resp_q;
      unique case (r_state_q)
         R_IDLE: if (bus.ar_valid_i) begin
            r_id_d     = bus.ar_id_i;
            rd_addr_d  = bus.ar_addr_i;
            rd_len_d   = bus.ar_len_i;
            rd_size_d  = bus.ar_size_i;
            rd_burst_d = bus.ar_burst_i;
            rd_cnt_d   = '0;
            r_state_d  = R_FETCH;
         end
         R_FETCH: begin
            r_data_d  = rd_oor ? '0 : mem_q[rd_addr_q[OffW +: IdxW]];
            r_resp_d  = rd_oor ? RespSlverr : RespOkay;
            r_state_d = R_DATA;
         end
         R_DATA: if (bus.r_ready_i) begin
            if (rd_cnt_q == rd_len_q) begin
               r_state_d = R_IDLE;
            end else begin
               rd_addr_d = next_addr(rd_addr_q, rd_size_q, rd_burst_q);
               rd_cnt_d  = rd_cnt_q + 8'd1;
               r_state_d = R_FETCH;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Write FSM: accept AW, take len+1 W beats, then hold B until accepted.
   always_comb begin
      w_state_d  = w_state_q;
      b_id_d     = b_id_q;
      wr_addr_d  = wr_addr_q;
      wr_len_d   = wr_len_q;
      wr_cnt_d   = wr_cnt_q;
      wr_size_d  = wr_size_q;
      wr_burst_d = wr_burst_q;
      b_err_d    = b_err_q;
      mem_we     = 1'b0;
      unique case (w_state_q)
         W_IDLE: if (bus.aw_valid_i) begin
            b_id_d     = bus.aw_id_i;
            wr_addr_d  = bus.aw_addr_i;
            wr_len_d   = bus.aw_len_i;
            wr_size_d  = bus.aw_size_i;
            wr_burst_d = bus.aw_burst_i;
            wr_cnt_d   = '0;
            b_err_d    = 1'b0;
            w_state_d  = W_DATA;
         end
         W_DATA: if (bus.w_valid_i) begin
            mem_we  = !wr_oor;
            b_err_d = b_err_q | wr_oor;
            if (wr_cnt_q == wr_len_q) begin
               w_state_d = W_RESP;
            end else begin
               wr_addr_d = next_addr(wr_addr_q, wr_size_q, wr_burst_q);
               wr_cnt_d  = wr_cnt_q + 8'd1;
            end
         end
         W_RESP: if (bus.b_ready_i) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   // Control and response registers, cleared by the synchronous reset.
   always_ff @(posedge clk_i) begin
      // NOTE: state is updated with <= so every flop samples the pre-edge values.
      if (rst_i) begin
         r_state_q  <= R_IDLE;
         r_id_q     <= '0;
         rd_addr_q  <= '0;
         rd_len_q   <= '0;
         rd_cnt_q   <= '0;
         rd_size_q  <= '0;
         rd_burst_q <= '0;
         r_data_q   <= '0;
         r_resp_q   <= '0;
         w_state_q  <= W_IDLE;
         b_id_q     <= '0;
         wr_addr_q  <= '0;
         wr_len_q   <= '0;
         wr_cnt_q   <= '0;
         wr_size_q  <= '0;
         wr_burst_q <= '0;
         b_err_q    <= 1'b0;
      end else begin
         r_state_q  <= r_state_d;
         r_id_q     <= r_id_d;
         rd_addr_q  <= rd_addr_d;
         rd_len_q   <= rd_len_d;
         rd_cnt_q   <= rd_cnt_d;
         rd_size_q  <= rd_size_d;
         rd_burst_q <= rd_burst_d;
         r_data_q   <= r_data_d;
         r_resp_q   <= r_resp_d;
         w_state_q  <= w_state_d;
         b_id_q     <= b_id_d;
         wr_addr_q  <= wr_addr_d;
         wr_len_q   <= wr_len_d;
         wr_cnt_q   <= wr_cnt_d;
         wr_size_q  <= wr_size_d;
         wr_burst_q <= wr_burst_d;
         b_err_q    <= b_err_d;
      end
   end

   // Byte-enabled array write; a same-cycle fetch still sees the old word.
   always_ff @(posedge clk_i) begin
      // NOTE: the array is deliberately not reset; contents survive rst_i.
      if (mem_we) begin
         for (int b = 0; b < StrbWidth; b++) begin
            if (bus.w_strb_i[b]) mem_q[wr_addr_q[OffW +: IdxW]][8*b +: 8] <= bus.w_data_i[8*b +: 8];
         end
      end
   end

   assign bus.ar_ready_o = (r_state_q == R_IDLE);
   assign bus.r_valid_o  = (r_state_q == R_DATA);
   assign bus.r_id_o     = r_id_q;
   assign bus.r_data_o   = r_data_q;
   assign bus.r_resp_o   = r_resp_q;
   assign bus.r_last_o   = (r_state_q == R_DATA) && (rd_cnt_q == rd_len_q);

   assign bus.aw_ready_o = (w_state_q == W_IDLE);
   assign bus.w_ready_o  = (w_state_q == W_DATA);
   assign bus.b_valid_o  = (w_state_q == W_RESP);
   assign bus.b_id_o     = b_id_q;
   assign bus.b_resp_o   = ((w_state_q == W_RESP) && b_err_q) ? RespSlverr : RespOkay;
endmodule
